lock_key_arbiter: RTL and testbench

Shares the single 4-bit `KEY` input of the digital lock FSM between two keypads: panel A (front) and panel B (rear). Each keypad input is debounced and reduced to one-cycle digit pulses. A whole code entry is granted to one keypad at a time, so digits from the two panels never interleave inside the lock's nibble registers. An inactivity timeout releases a stalled owner.

---
 rtl/lock_key_arbiter_pkg.sv | 20 ++
 rtl/lock_key_arbiter_debounce.sv | 62 ++++++
 rtl/lock_key_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_lock_key_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_key_arbiter_pkg.sv
// Shared definitions for the keypad arbiter and the digital lock it feeds.
// Holds the arbiter state encoding, the owner codes driven on OWNER and the
// lock's combination length.
package lock_key_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_t;

    localparam int LOCK_DIGITS = 4;

endpackage

// File: rtl/lock_key_arbiter_debounce.sv
// key_debounce: filters one raw 4-bit keypad code and reduces each accepted
// press to a single-cycle event.
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous, active-high
//   raw    - raw keypad code, 0 = no key
//   deb    - debounced keypad code
//   press  - one-cycle pulse on the cycle deb goes from 0 to non-zero
//   code   - debounced code accompanying press, 0 otherwise
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw,
    output logic [3:0] deb,
    output logic       press,
    output logic [3:0] code
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [3:0]       r_raw_q;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_deb;
    logic             r_press;
    logic [3:0]       r_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_raw_q <= 4'd0;
            r_cnt   <= '0;
            r_deb   <= 4'd0;
            r_press <= 1'b0;
            r_code  <= 4'd0;
        end else begin
            r_raw_q <= raw;
            r_press <= 1'b0;
            r_code  <= 4'd0;
            if (raw != r_raw_q) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // raw_q has matched its predecessors long enough; accept it even
            // if raw moves on this very edge.
            if (r_cnt == CNT_MAX) begin
                r_deb <= r_raw_q;
                if (r_deb == 4'd0 && r_raw_q != 4'd0) begin
                    r_press <= 1'b1;
                    r_code  <= r_raw_q;
                end
            end
        end
    end

    assign deb   = r_deb;
    assign press = r_press;
    assign code  = r_code;

endmodule

// File: rtl/lock_key_arbiter.sv
// lock_key_arbiter: shares the lock's single KEY input between keypad panel A
// (front) and panel B (rear). A whole code entry belongs to one panel; the
// other panel's presses are dropped until the entry completes or times out.
// Ports:
//   clock   - single clock, rising edge
//   reset   - synchronous, active-high
//   KEY_A   - raw panel A code, 0 = no key
//   KEY_B   - raw panel B code, 0 = no key
//   KEY     - digit to the lock, non-zero for one cycle per accepted press
//   OWNER   - 00 none, 01 A, 10 B
//   BUSY    - high while an entry is owned, including the HOLD cycle
//   DENIED  - one-cycle pulse when a press is dropped
//   TIMEOUT - one-cycle pulse when an idle owner is released
module lock_key_arbiter
    import lock_key_arbiter_pkg::*;
#(
    parameter int DEBOUNCE       = 4,
    parameter int DIGITS         = LOCK_DIGITS,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] KEY_A,
    input  logic [3:0] KEY_B,
    output logic [3:0] KEY,
    output logic [1:0] OWNER,
    output logic       BUSY,
    output logic       DENIED,
    output logic       TIMEOUT
);

    localparam int DCNT_W = $clog2(DIGITS + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIGITS);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

    logic [3:0] w_deb_a_unused, w_deb_b_unused;
    logic       w_press_a, w_press_b;
    logic [3:0] w_code_a, w_code_b;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clock (clock),
        .reset (reset),
        .raw   (KEY_A),
        .deb   (w_deb_a_unused),
        .press (w_press_a),
        .code  (w_code_a)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clock (clock),
        .reset (reset),
        .raw   (KEY_B),
        .deb   (w_deb_b_unused),
        .press (w_press_b),
        .code  (w_code_b)
    );

    arb_state_t        r_state, w_state_n;
    owner_t            r_owner, w_owner_n;
    logic              r_last_b, w_last_b_n;  // 1: panel B was served last
    logic [DCNT_W-1:0] r_dcnt, w_dcnt_n;
    logic [TMR_W-1:0]  r_timer, w_timer_n;
    logic [3:0]        r_key, w_key_n;
    logic              r_busy, w_busy_n;
    logic              r_denied, w_denied_n;
    logic              r_timeout, w_timeout_n;

    logic       w_own_press, w_other_press;
    logic [3:0] w_own_code;
    logic       w_grant_a, w_grant_b;

    // Map the two panels onto owner / intruder roles.
    always_comb begin
        w_own_press   = 1'b0;
        w_other_press = 1'b0;
        w_own_code    = 4'd0;
        if (r_owner == OWN_A) begin
            w_own_press   = w_press_a;
            w_own_code    = w_code_a;
            w_other_press = w_press_b;
        end else if (r_owner == OWN_B) begin
            w_own_press   = w_press_b;
            w_own_code    = w_code_b;
            w_other_press = w_press_a;
        end
    end

    // On a tie the panel not served last wins.
    assign w_grant_a = w_press_a && (!w_press_b || r_last_b);
    assign w_grant_b = w_press_b && (!w_press_a || !r_last_b);

    always_comb begin
        w_state_n   = r_state;
        w_owner_n   = r_owner;
        w_last_b_n  = r_last_b;
        w_dcnt_n    = r_dcnt;
        w_timer_n   = r_timer;
        w_key_n     = 4'd0;
        w_denied_n  = 1'b0;
        w_timeout_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_denied_n = w_press_a && w_press_b;
                if (w_grant_a || w_grant_b) begin
                    w_state_n = ST_OWN;
                    w_owner_n = w_grant_a ? OWN_A : OWN_B;
                    w_key_n   = w_grant_a ? w_code_a : w_code_b;
                    w_dcnt_n  = DCNT_W'(1);
                    w_timer_n = '0;
                end
            end
            ST_OWN: begin
                if (r_dcnt == DCNT_LAST) begin
                    // Last digit went out on the previous edge.
                    w_state_n  = ST_HOLD;
                    w_denied_n = w_press_a || w_press_b;
                end else if (r_timer == TMR_MAX) begin
                    w_state_n   = ST_IDLE;
                    w_timeout_n = 1'b1;
                    w_denied_n  = w_press_a || w_press_b;
                    w_last_b_n  = (r_owner == OWN_B);
                    w_owner_n   = OWN_NONE;
                    w_dcnt_n    = '0;
                    w_timer_n   = '0;
                end else begin
                    w_denied_n = w_other_press;
                    if (w_own_press) begin
                        w_key_n   = w_own_code;
                        w_dcnt_n  = r_dcnt + DCNT_W'(1);
                        w_timer_n = '0;
                    end else if (r_timer != TMR_MAX) begin
                        w_timer_n = r_timer + TMR_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Lock compare cycle: nothing forwarded, everything dropped.
                w_state_n  = ST_IDLE;
                w_denied_n = w_press_a || w_press_b;
                w_last_b_n = (r_owner == OWN_B);
                w_owner_n  = OWN_NONE;
                w_dcnt_n   = '0;
                w_timer_n  = '0;
            end
            default: begin
                w_state_n = ST_IDLE;
                w_owner_n = OWN_NONE;
            end
        endcase
        w_busy_n = (w_state_n != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_NONE;
            r_last_b  <= 1'b1;
            r_dcnt    <= '0;
            r_timer   <= '0;
            r_key     <= 4'd0;
            r_busy    <= 1'b0;
            r_denied  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_owner   <= w_owner_n;
            r_last_b  <= w_last_b_n;
            r_dcnt    <= w_dcnt_n;
            r_timer   <= w_timer_n;
            r_key     <= w_key_n;
            r_busy    <= w_busy_n;
            r_denied  <= w_denied_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign KEY     = r_key;
    assign OWNER   = r_owner;
    assign BUSY    = r_busy;
    assign DENIED  = r_denied;
    assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_lock_key_arbiter.sv
module tb_lock_key_arbiter;

    localparam int DEB = 2;
    localparam int TMO = 20;
    localparam int DIG = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY_A, KEY_B, KEY;
    logic [1:0] OWNER;
    logic       BUSY, DENIED, TIMEOUT;

    lock_key_arbiter #(.DEBOUNCE(DEB), .DIGITS(DIG), .TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clk),
        .reset   (reset),
        .KEY_A   (KEY_A),
        .KEY_B   (KEY_B),
        .KEY     (KEY),
        .OWNER   (OWNER),
        .BUSY    (BUSY),
        .DENIED  (DENIED),
        .TIMEOUT (TIMEOUT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h required %0h", name, cyc, got, exp);
        end
    endfunction

    // Expected DUT activity for one clock edge.
    typedef struct {
        int         edge_n;
        logic [3:0] key;
        logic       den;
        logic       tmo;
        logic [1:0] own;
        logic       busy;
    } exp_t;
    exp_t sb[$];

    // Reference model: debounced presses from raw-sample history, entries
    // tracked as owner / digits taken / idle cycles / trailing cycles.
    logic [3:0] h_a[$], h_b[$];
    logic [3:0] d_a = 0, d_b = 0, c_a = 0, c_b = 0;
    bit         p_a = 0, p_b = 0;
    int         m_owner = 0, m_digits = 0, m_idle = 0, m_wrap = 0;
    bit         m_last_b = 1;
    logic [1:0] ms_own = 0;
    bit         ms_busy = 0;

    // True when the last DEB+1 samples since reset are all equal.
    function automatic bit stable_win(input logic [3:0] h[$]);
        if (h.size() < DEB + 1) return 1'b0;
        foreach (h[i]) if (h[i] != h[h.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(int n, logic rst, logic [3:0] ra, logic [3:0] rb);
        logic [3:0] key = 0;
        bit den = 0, tmo = 0, busy;
        logic [3:0] nd;
        exp_t e;
        // Outputs at edge n come from presses detected at edge n-1.
        if (rst) begin
            m_owner = 0; m_digits = 0; m_idle = 0; m_wrap = 0; m_last_b = 1;
        end else if (m_owner == 0) begin
            int w = 0;
            if (p_a && p_b) begin den = 1; w = m_last_b ? 1 : 2; end
            else if (p_a) w = 1;
            else if (p_b) w = 2;
            if (w != 0) begin
                m_owner = w; key = (w == 1) ? c_a : c_b;
                m_digits = 1; m_idle = 0; m_wrap = (DIG == 1) ? 2 : 0;
            end
        end else if (m_wrap > 0) begin
            den = p_a | p_b;
            m_wrap--;
            if (m_wrap == 0) begin m_last_b = (m_owner == 2); m_owner = 0; end
        end else if (m_idle >= TMO) begin
            tmo = 1; den = p_a | p_b;
            m_last_b = (m_owner == 2); m_owner = 0;
        end else begin
            bit op = (m_owner == 1) ? p_a : p_b;
            den = (m_owner == 1) ? p_b : p_a;
            if (op) begin
                key = (m_owner == 1) ? c_a : c_b;
                m_digits++; m_idle = 0;
                if (m_digits == DIG) m_wrap = 2;
            end else m_idle++;
        end
        busy = (m_owner != 0);
        if (key != 0 || den || tmo || 2'(m_owner) != ms_own || busy != ms_busy) begin
            e.edge_n = n; e.key = key; e.den = den; e.tmo = tmo;
            e.own = 2'(m_owner); e.busy = busy;
            sb.push_back(e);
        end
        ms_own = 2'(m_owner); ms_busy = busy;
        // Presses detected at edge n.
        if (rst) begin
            p_a = 0; p_b = 0; d_a = 0; d_b = 0; c_a = 0; c_b = 0;
            h_a = {4'd0}; h_b = {4'd0};
        end else begin
            nd = d_a; if (stable_win(h_a)) nd = h_a[h_a.size()-1];
            p_a = (d_a == 0 && nd != 0); c_a = nd; d_a = nd;
            h_a.push_back(ra); if (h_a.size() > DEB + 1) void'(h_a.pop_front());
            nd = d_b; if (stable_win(h_b)) nd = h_b[h_b.size()-1];
            p_b = (d_b == 0 && nd != 0); c_b = nd; d_b = nd;
            h_b.push_back(rb); if (h_b.size() > DEB + 1) void'(h_b.pop_front());
        end
    endfunction

    task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic rst);
        @(negedge clk);
        KEY_A = a; KEY_B = b; reset = rst;
        model_step(cyc + 1, rst, a, b);
    endtask

    task automatic press(input logic [3:0] a, input logic [3:0] b, input int hold, input int gap);
        repeat (hold) cycle(a, b, 1'b0);
        repeat (gap) cycle(4'd0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'd0, 4'd0, 1'b0);
    endtask

    task automatic reset_pulse(input string tag);
        cycle(4'd0, 4'd0, 1'b1);
        @(posedge clk); #1;
        check({tag, "_KEY"}, KEY, 0);
        check({tag, "_OWNER"}, OWNER, 0);
        check({tag, "_BUSY"}, BUSY, 0);
        check({tag, "_DENIED"}, DENIED, 0);
        check({tag, "_TIMEOUT"}, TIMEOUT, 0);
    endtask

    // Monitor: any activity or OWNER/BUSY change must match the next expectation.
    bit         mon_en = 0;
    logic [1:0] mon_own = 0;
    logic       mon_busy = 0;
    exp_t       mon_item;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (KEY !== 4'd0 || DENIED !== 1'b0 || TIMEOUT !== 1'b0 ||
                    OWNER !== mon_own || BUSY !== mon_busy) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output at edge %0d: KEY=%0h OWNER=%0b BUSY=%0b DENIED=%0b TIMEOUT=%0b, required no activity",
                                 cyc, KEY, OWNER, BUSY, DENIED, TIMEOUT);
                    end else begin
                        mon_item = sb.pop_front();
                        check("event_edge", cyc, mon_item.edge_n);
                        check("KEY", KEY, mon_item.key);
                        check("DENIED", DENIED, mon_item.den);
                        check("TIMEOUT", TIMEOUT, mon_item.tmo);
                        check("OWNER", OWNER, mon_item.own);
                        check("BUSY", BUSY, mon_item.busy);
                    end
                end
                mon_own = OWNER; mon_busy = BUSY;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] ra = 0, rb = 0;
    int ra_left = 0, rb_left = 0;

    initial begin
        reset = 1'b1; KEY_A = 4'd0; KEY_B = 4'd0;
        repeat (2) cycle(4'd0, 4'd0, 1'b1);
        reset_pulse("reset");
        mon_en = 1;

        // Single-panel entry
        press(3, 0, 4, 4); press(5, 0, 4, 4); press(7, 0, 4, 4); press(9, 0, 4, 4);
        idle(6);

        // Bounce filter, then the lone digit times out
        for (int i = 0; i < 10; i++) cycle((i % 2) ? 4'd6 : 4'd0, 4'd0, 1'b0);
        press(6, 0, 6, 4);
        idle(TMO + 5);

        // Simultaneous presses after reset: A first, then B
        reset_pulse("tie_reset");
        idle(2);
        press(1, 2, 4, 4); press(3, 0, 4, 4); press(4, 0, 4, 4); press(5, 0, 4, 4);
        idle(4);
        press(6, 7, 4, 4); press(0, 8, 4, 4); press(0, 9, 4, 4); press(0, 1, 4, 4);
        idle(4);

        // Intrusion by B during A's third digit
        press(1, 0, 4, 4); press(2, 0, 4, 4);
        cycle(3, 0, 0); cycle(3, 8, 0); cycle(3, 8, 0); cycle(3, 8, 0);
        cycle(0, 8, 0); cycle(0, 8, 0); idle(4);
        press(4, 0, 4, 4);
        idle(4);

        // Timeout, then B takes over
        press(2, 0, 4, 4); press(5, 0, 4, 4);
        idle(TMO + 5);
        press(0, 9, 4, 4); press(0, 8, 4, 4); press(0, 7, 4, 4); press(0, 6, 4, 4);
        idle(4);

        // Reset mid-entry, then a full fresh entry
        press(1, 0, 4, 4);
        press(2, 0, 4, 1);
        reset_pulse("midreset");
        idle(2);
        press(4, 0, 4, 4); press(3, 0, 4, 4); press(2, 0, 4, 4); press(1, 0, 4, 4);
        idle(4);

        // Random traffic on both panels
        repeat (400) begin
            if (ra_left == 0) begin
                ra = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                ra_left = $urandom_range(1, 8);
            end
            if (rb_left == 0) begin
                rb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                rb_left = $urandom_range(1, 8);
            end
            cycle(ra, rb, 1'b0);
            ra_left--; rb_left--;
        end
        idle(TMO + 15);

        @(posedge clk);
        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
